// File: rtl/hack_rom_loader.sv
// Hack ROM download controller: frames UART bytes into 16-bit ROM words,
// verifies an XOR checksum and hands the machine to the CPU on success.
module hack_rom_loader #(
  parameter int         ROM_DEPTH      = 256,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        CLK,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_dv,
  input  logic        i_load_req,
  output logic [15:0] o_rom_addr,
  output logic [15:0] o_rom_data,
  output logic        o_rom_write,
  output logic        o_mode,
  output logic        o_busy,
  output logic        o_error,
  output logic [1:0]  o_error_code,
  output logic [15:0] o_words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] DEPTH = 16'(ROM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_t;

  state_t        state;
  logic [7:0]    len_hi;
  logic [15:0]   len;
  logic [7:0]    hi;
  logic [7:0]    csum;
  logic [TW-1:0] tcnt;

  logic          in_frame;
  logic          expired;
  logic          is_sync;
  logic [15:0]   len_now;
  logic [15:0]   cnt_next;

  assign in_frame = state inside {S_LEN_HI, S_LEN_LO, S_DATA_HI,
                                  S_DATA_LO, S_CSUM};
  assign expired  = in_frame && (tcnt == T_LAST);
  assign is_sync  = i_rx_dv && (i_rx_byte == SYNC_BYTE);
  assign len_now  = {len_hi, i_rx_byte};
  assign cnt_next = o_words_loaded + 16'd1;

  // Frame FSM; all outputs are registered alongside the state.
  always_ff @(posedge CLK or posedge i_reset) begin
    if (i_reset) begin
      state          <= S_IDLE;
      len_hi         <= '0;
      len            <= '0;
      hi             <= '0;
      csum           <= '0;
      tcnt           <= '0;
      o_rom_addr     <= '0;
      o_rom_data     <= '0;
      o_rom_write    <= 1'b0;
      o_mode         <= 1'b0;
      o_busy         <= 1'b0;
      o_error        <= 1'b0;
      o_error_code   <= '0;
      o_words_loaded <= '0;
    end else begin
      o_rom_write <= 1'b0;
      if (i_load_req) begin
        state   <= S_IDLE;
        o_mode  <= 1'b0;
        o_busy  <= 1'b0;
        o_error <= 1'b0;
        tcnt    <= '0;
      end else if (expired) begin
        // Expiry wins over a byte landing on the same edge.
        state        <= S_ERROR;
        o_busy       <= 1'b0;
        o_error      <= 1'b1;
        o_error_code <= 2'd2;
        tcnt         <= '0;
      end else begin
        if (in_frame) begin
          tcnt <= i_rx_dv ? '0 : tcnt + TW'(1);
        end
        unique case (state)
          S_IDLE, S_ERROR: begin
            if (is_sync) begin
              state          <= S_LEN_HI;
              o_busy         <= 1'b1;
              o_error        <= 1'b0;
              o_error_code   <= '0;
              o_words_loaded <= '0;
              csum           <= '0;
              len            <= '0;
              tcnt           <= '0;
            end
          end
          S_LEN_HI: begin
            if (i_rx_dv) begin
              len_hi <= i_rx_byte;
              csum   <= csum ^ i_rx_byte;
              state  <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (i_rx_dv) begin
              len  <= len_now;
              csum <= csum ^ i_rx_byte;
              if (len_now > DEPTH) begin
                state        <= S_ERROR;
                o_busy       <= 1'b0;
                o_error      <= 1'b1;
                o_error_code <= 2'd1;
              end else if (len_now == 16'd0) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA_HI;
              end
            end
          end
          S_DATA_HI: begin
            if (i_rx_dv) begin
              hi    <= i_rx_byte;
              csum  <= csum ^ i_rx_byte;
              state <= S_DATA_LO;
            end
          end
          S_DATA_LO: begin
            if (i_rx_dv) begin
              o_rom_write    <= 1'b1;
              o_rom_addr     <= o_words_loaded;
              o_rom_data     <= {hi, i_rx_byte};
              o_words_loaded <= cnt_next;
              csum           <= csum ^ i_rx_byte;
              state <= (cnt_next == len) ? S_CSUM : S_DATA_HI;
            end
          end
          S_CSUM: begin
            if (i_rx_dv) begin
              o_busy <= 1'b0;
              if (i_rx_byte == csum) begin
                state  <= S_RUN;
                o_mode <= 1'b1;
              end else begin
                state        <= S_ERROR;
                o_error      <= 1'b1;
                o_error_code <= 2'd3;
              end
            end
          end
          S_RUN: begin
            o_mode <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader: byte table with expected status,
// plus hand sequences for reset, timeout and load-request corners.
module tb_hack_rom_loader;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxb = '0;
  logic        dv  = 1'b0;
  logic        req = 1'b0;
  logic [15:0] addr;
  logic [15:0] data;
  logic        wr;
  logic        mode;
  logic        busy;
  logic        err;
  logic [1:0]  code;
  logic [15:0] words;

  hack_rom_loader #(
    .ROM_DEPTH(256),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK(clk),
    .i_reset(rst),
    .i_rx_byte(rxb),
    .i_rx_dv(dv),
    .i_load_req(req),
    .o_rom_addr(addr),
    .o_rom_data(data),
    .o_rom_write(wr),
    .o_mode(mode),
    .o_busy(busy),
    .o_error(err),
    .o_error_code(code),
    .o_words_loaded(words)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] wa[$];
  logic [15:0] wd[$];

  // Record every ROM write strobe seen at the falling edge.
  always @(negedge clk) begin
    if (wr) begin
      wa.push_back(addr);
      wd.push_back(data);
    end
  end

  typedef struct {
    logic        req;
    logic [7:0]  b;
    logic [20:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic r, input logic [7:0] b,
                              input logic m, input logic bs,
                              input logic e, input logic [1:0] c,
                              input logic [15:0] w);
    vec_t v;
    v.req = r;
    v.b   = b;
    v.exp = {m, bs, e, c, w};
    tv.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [20:0] stat();
    return {mode, busy, err, code, words};
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rxb = b;
    dv  = 1'b1;
    @(negedge clk);
    dv  = 1'b0;
    #1;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    #1;
  endtask

  logic [15:0] exp_a[5];
  logic [15:0] exp_d[5];

  initial begin
    // Frame 1: two words, good checksum (00^02^12^34^AB^CD = 42).
    add(0, 8'hA5, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0);
    add(0, 8'h02, 0, 1, 0, 0, 0);
    add(0, 8'h12, 0, 1, 0, 0, 0);
    add(0, 8'h34, 0, 1, 0, 0, 1);
    add(0, 8'hAB, 0, 1, 0, 0, 1);
    add(0, 8'hCD, 0, 1, 0, 0, 2);
    add(0, 8'h42, 1, 0, 0, 0, 2);
    add(0, 8'hA5, 1, 0, 0, 0, 2);
    add(1, 8'h00, 0, 0, 0, 0, 2);
    add(0, 8'h33, 0, 0, 0, 0, 2);
    // Frame 2: same payload, bad checksum.
    add(0, 8'hA5, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0);
    add(0, 8'h02, 0, 1, 0, 0, 0);
    add(0, 8'h12, 0, 1, 0, 0, 0);
    add(0, 8'h34, 0, 1, 0, 0, 1);
    add(0, 8'hAB, 0, 1, 0, 0, 1);
    add(0, 8'hCD, 0, 1, 0, 0, 2);
    add(0, 8'h41, 0, 0, 1, 3, 2);
    // Oversized length 257.
    add(0, 8'hA5, 0, 1, 0, 0, 0);
    add(0, 8'h01, 0, 1, 0, 0, 0);
    add(0, 8'h01, 0, 0, 1, 1, 0);
    // Empty frame runs with no writes.
    add(0, 8'hA5, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0);

    exp_a[0] = 16'd0; exp_d[0] = 16'h1234;
    exp_a[1] = 16'd1; exp_d[1] = 16'hABCD;
    exp_a[2] = 16'd0; exp_d[2] = 16'h1234;
    exp_a[3] = 16'd1; exp_d[3] = 16'hABCD;
    exp_a[4] = 16'd0; exp_d[4] = 16'hBEEF;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_status", {11'd0, stat()}, 32'd0);
    chk("reset_rom", {addr, data}, 32'd0);
    chk("reset_wr", {31'd0, wr}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].req) pulse_req();
      else send(tv[i].b);
      chk($sformatf("vec%0d", i), {11'd0, stat()}, {11'd0, tv[i].exp});
    end

    repeat (2) @(negedge clk);
    #1;
    chk("rom_hold", {addr, data}, {16'd1, 16'hABCD});
    chk("writes_after_table", wa.size(), 4);

    // Asynchronous reset in the middle of a frame.
    pulse_req();
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midreset_status", {11'd0, stat()}, 32'd0);
    chk("midreset_rom", {addr, data, 15'd0, wr}, 48'd0);
    @(negedge clk);
    rst = 1'b0;
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'hBE);
    send(8'hEF);
    send(8'h50);
    chk("after_reset_frame", {11'd0, stat()}, {11'd0, 5'b10000, 16'd1});

    // Inter-byte timeout with a byte landing on the expiry edge.
    pulse_req();
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h12);
    repeat (T - 1) @(negedge clk);
    #1;
    chk("pre_timeout", {11'd0, stat()}, {11'd0, 5'b01000, 16'd0});
    rxb = 8'h34;
    dv  = 1'b1;
    @(negedge clk);
    dv  = 1'b0;
    #1;
    chk("timeout", {11'd0, stat()}, {11'd0, 5'b00110, 16'd0});
    send(8'h56);
    chk("error_hold", {11'd0, stat()}, {11'd0, 5'b00110, 16'd0});
    repeat (3) @(negedge clk);
    #1;
    chk("writes_after_timeout", wa.size(), 5);

    // Load request beats a simultaneous SYNC while running.
    send(8'hA5);
    chk("error_cleared", {11'd0, stat()}, {11'd0, 5'b01000, 16'd0});
    send(8'h00);
    send(8'h00);
    send(8'h00);
    chk("run_again", {31'd0, mode}, 32'd1);
    @(negedge clk);
    req = 1'b1;
    rxb = 8'hA5;
    dv  = 1'b1;
    @(negedge clk);
    req = 1'b0;
    dv  = 1'b0;
    #1;
    chk("req_vs_sync", {11'd0, stat()}, 32'd0);
    send(8'h00);
    chk("stray_00", {11'd0, stat()}, 32'd0);
    send(8'hFF);
    chk("stray_ff", {11'd0, stat()}, 32'd0);

    repeat (3) @(negedge clk);
    #1;
    chk("write_total", wa.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wa.size()) begin
        chk($sformatf("write%0d", i), {wa[i], wd[i]}, {exp_a[i], exp_d[i]});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
